ctl_pic: RTL and testbench

CTL_PIC -- requirements
Module: ctl_pic

---
 rtl/ctl_pic.sv | 198 +++++++++++++++++++
 tb/tb_ctl_pic.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctl_pic.sv
// Interrupt controller with edge-triggered request capture, masking, fully nested
// priority arbitration (fixed or rotating), and a 5-byte I/O register window.
module ctl_pic #(
   parameter int          CHANNELS    = 8,
   parameter logic [7:0]  VECTOR_BASE = 8'h08,
   parameter logic [15:0] PORT_BASE   = 16'h0020,
   parameter logic [15:0] IMR_RESET   = 16'h0000
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [CHANNELS-1:0] irq_in,
   input  logic [15:0]         port_address,
   input  logic [7:0]          port_out,
   input  logic                port_write,
   input  logic                port_read,
   output logic [7:0]          port_in,
   output logic                port_ready,
   input  logic                irq_ack,
   output logic                irq_signal,
   output logic [7:0]          irq
);

   localparam logic [15:0] CHAN_MASK  = 16'((33'd1 << CHANNELS) - 33'd1);
   localparam logic [4:0]  CHAN_COUNT = 5'(CHANNELS);

   typedef enum logic {IDLE, REQ} state_t;

   state_t      state_q, state_d;
   logic [3:0]  chan_q, chan_d;
   logic [3:0]  base_q, base_d;
   logic        rotate_q, rotate_d;
   logic [15:0] irr_q, irr_d;
   logic [15:0] isr_q, isr_d;
   logic [15:0] imr_q, imr_d;
   logic [15:0] irqPrev_q;
   logic        armed_q;
   logic [7:0]  portIn_q, portIn_d;
   logic        portReady_q;

   logic [15:0] irqIn16, edges, pending;
   logic [15:0] offset;
   logic        inWindow, wrCmd, wrImrLo, wrImrHi;
   logic [7:0]  readData;
   logic        pendFound, isrFound, eligible;
   logic [3:0]  pendIdx, pendRank, isrIdx, isrRank, scanIdx;
   logic        eoiHit;
   logic [3:0]  eoiChan;
   logic [15:0] eoiMask, ackMask;

   function automatic logic [3:0] wrapIdx(input logic [4:0] v);
      if (v >= CHAN_COUNT) return 4'(v - CHAN_COUNT);
      return v[3:0];
   endfunction

   // armed_q suppresses the first sample after reset so a line held high through reset is not an edge
   assign irqIn16  = 16'(irq_in);
   assign edges    = irqIn16 & ~irqPrev_q & {16{armed_q}};
   assign pending  = irr_q & ~imr_q;

   assign offset   = port_address - PORT_BASE;
   assign inWindow = (offset < 16'd5);
   assign wrCmd    = port_write & inWindow & (offset == 16'd0);
   assign wrImrLo  = port_write & inWindow & (offset == 16'd1);
   assign wrImrHi  = port_write & inWindow & (offset == 16'd2);

   // Scan channels from the current highest-priority one; rank 0 is the highest priority
   always_comb begin
      pendFound = 1'b0;
      pendIdx   = '0;
      pendRank  = '0;
      isrFound  = 1'b0;
      isrIdx    = '0;
      isrRank   = '0;
      scanIdx   = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         scanIdx = wrapIdx({1'b0, base_q} + 5'(i));
         if (!pendFound && pending[scanIdx]) begin
            pendFound = 1'b1;
            pendIdx   = scanIdx;
            pendRank  = 4'(i);
         end
         if (!isrFound && isr_q[scanIdx]) begin
            isrFound = 1'b1;
            isrIdx   = scanIdx;
            isrRank  = 4'(i);
         end
      end
   end

   assign eligible = pendFound && (!isrFound || (isrRank > pendRank));

   always_comb begin
      eoiHit  = 1'b0;
      eoiChan = '0;
      eoiMask = '0;
      if (wrCmd) begin
         if (port_out == 8'h20) begin
            eoiHit  = isrFound;
            eoiChan = isrIdx;
         end else if ((port_out[7:4] == 4'h6) && ({1'b0, port_out[3:0]} < CHAN_COUNT)
                      && isr_q[port_out[3:0]]) begin
            eoiHit  = 1'b1;
            eoiChan = port_out[3:0];
         end
      end
      if (eoiHit) eoiMask = 16'd1 << eoiChan;
   end

   always_comb begin
      state_d = state_q;
      chan_d  = chan_q;
      ackMask = '0;
      case (state_q)
         IDLE: begin
            if (eligible) begin
               state_d = REQ;
               chan_d  = pendIdx;
            end
         end
         REQ: begin
            if (irq_ack) begin
               state_d = IDLE;
               ackMask = 16'd1 << chan_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // EOI is applied to the pre-ack ISR so a same-cycle ack is never cleared by it
   always_comb begin
      isr_d    = ((isr_q & ~eoiMask) | ackMask) & CHAN_MASK;
      irr_d    = ((irr_q & ~ackMask) | edges) & CHAN_MASK;
      imr_d    = imr_q;
      rotate_d = rotate_q;
      base_d   = base_q;
      if (wrImrLo) imr_d[7:0]  = port_out;
      if (wrImrHi) imr_d[15:8] = port_out;
      imr_d = imr_d & CHAN_MASK;
      if (wrCmd && (port_out == 8'hA0)) begin
         rotate_d = 1'b0;
         base_d   = '0;
      end else if (wrCmd && (port_out == 8'hA8)) begin
         rotate_d = 1'b1;
      end else if (rotate_q && eoiHit) begin
         base_d = wrapIdx({1'b0, eoiChan} + 5'd1);
      end
   end

   always_comb begin
      readData = 8'h00;
      if (inWindow) begin
         case (offset[2:0])
            3'd0:    readData = irr_q[7:0];
            3'd1:    readData = imr_q[7:0];
            3'd2:    readData = imr_q[15:8];
            3'd3:    readData = isr_q[7:0];
            3'd4:    readData = isr_q[15:8];
            default: readData = 8'h00;
         endcase
      end
      portIn_d = port_read ? readData : 8'h00;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         chan_q      <= '0;
         base_q      <= '0;
         rotate_q    <= 1'b0;
         irr_q       <= '0;
         isr_q       <= '0;
         imr_q       <= IMR_RESET & CHAN_MASK;
         irqPrev_q   <= '0;
         armed_q     <= 1'b0;
         portIn_q    <= 8'h00;
         portReady_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         chan_q      <= chan_d;
         base_q      <= base_d;
         rotate_q    <= rotate_d;
         irr_q       <= irr_d;
         isr_q       <= isr_d;
         imr_q       <= imr_d;
         irqPrev_q   <= irqIn16;
         armed_q     <= 1'b1;
         portIn_q    <= portIn_d;
         portReady_q <= port_read | port_write;
      end
   end

   assign port_in    = portIn_q;
   assign port_ready = portReady_q;
   assign irq_signal = (state_q == REQ);
   assign irq        = (state_q == REQ) ? (VECTOR_BASE + {4'b0000, chan_q}) : 8'h00;

endmodule

// File: tb/tb_ctl_pic.sv
// Self-checking bench for ctl_pic: table-driven register accesses plus hand-written
// interrupt sequences; read data is checked through a scoreboard queue.
module tb_ctl_pic;

   localparam int CHANNELS = 8;

   logic                clock = 1'b0;
   logic                reset_n;
   logic [CHANNELS-1:0] irq_in;
   logic [15:0]         port_address;
   logic [7:0]          port_out;
   logic                port_write;
   logic                port_read;
   logic [7:0]          port_in;
   logic                port_ready;
   logic                irq_ack;
   logic                irq_signal;
   logic [7:0]          irq;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  value;
   } sbEntry_t;

   typedef struct {
      logic        isWrite;
      logic [15:0] addr;
      logic [7:0]  data;
      logic [7:0]  expRead;
   } busVec_t;

   sbEntry_t readQueue[$];
   sbEntry_t sbHead;
   logic     sawRead, sawStrobe;

   always #5 clock = ~clock;

   ctl_pic #(
      .CHANNELS(CHANNELS),
      .VECTOR_BASE(8'h08),
      .PORT_BASE(16'h0020),
      .IMR_RESET(16'h0000)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .irq_in(irq_in),
      .port_address(port_address),
      .port_out(port_out),
      .port_write(port_write),
      .port_read(port_read),
      .port_in(port_in),
      .port_ready(port_ready),
      .irq_ack(irq_ack),
      .irq_signal(irq_signal),
      .irq(irq)
   );

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic busWrite(input logic [15:0] addr, input logic [7:0] data);
      port_address = addr;
      port_out     = data;
      port_write   = 1'b1;
      tick();
      port_write   = 1'b0;
   endtask

   task automatic busRead(input logic [15:0] addr, input logic [7:0] expected);
      sbEntry_t e;
      e.addr  = addr;
      e.value = expected;
      readQueue.push_back(e);
      port_address = addr;
      port_read    = 1'b1;
      tick();
      port_read    = 1'b0;
   endtask

   task automatic pulseAck();
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
   endtask

   task automatic waitIrq(input string name, input logic [7:0] expVec, input int maxCycles);
      int n = 0;
      while (!irq_signal && n < maxCycles) begin
         tick();
         n++;
      end
      if (!irq_signal) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s: irq_signal still 0 after %0d cycles, expected vector %h", name, n, expVec);
      end else begin
         checkOutput(name, 16'(irq), 16'(expVec));
      end
   endtask

   task automatic expectIdle(input string name, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         tick();
         checkOutput(name, 16'(irq_signal), 16'd0);
      end
   endtask

   // Register-window vectors with default parameters: CHANNELS=8, PORT_BASE=0x20
   task automatic applyStimulus();
      busVec_t vecs[12];
      vecs[0]  = '{1'b0, 16'h0021, 8'h00, 8'h00};
      vecs[1]  = '{1'b0, 16'h0020, 8'h00, 8'h00};
      vecs[2]  = '{1'b1, 16'h0021, 8'hA5, 8'h00};
      vecs[3]  = '{1'b0, 16'h0021, 8'h00, 8'hA5};
      vecs[4]  = '{1'b1, 16'h0022, 8'hFF, 8'h00};
      vecs[5]  = '{1'b0, 16'h0022, 8'h00, 8'h00};
      vecs[6]  = '{1'b0, 16'h0023, 8'h00, 8'h00};
      vecs[7]  = '{1'b0, 16'h0024, 8'h00, 8'h00};
      vecs[8]  = '{1'b0, 16'h0025, 8'h00, 8'h00};
      vecs[9]  = '{1'b0, 16'h001F, 8'h00, 8'h00};
      vecs[10] = '{1'b1, 16'h0021, 8'h00, 8'h00};
      vecs[11] = '{1'b0, 16'h0021, 8'h00, 8'h00};
      for (int i = 0; i < 12; i++) begin
         if (vecs[i].isWrite) busWrite(vecs[i].addr, vecs[i].data);
         else                 busRead(vecs[i].addr, vecs[i].expRead);
      end
   endtask

   // Every strobe must be answered by exactly one port_ready cycle; reads pop the scoreboard
   always begin
      @(posedge clock);
      sawRead   = port_read;
      sawStrobe = port_read | port_write;
      #2;
      if (sawStrobe || port_ready) checkOutput("portReady", 16'(port_ready), 16'(sawStrobe));
      if (sawRead) begin
         if (readQueue.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: read completed with no expected entry, got %h", port_in);
         end else begin
            sbHead = readQueue.pop_front();
            checkOutput($sformatf("read@%h", sbHead.addr), 16'(port_in), 16'(sbHead.value));
         end
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset_n      = 1'b0;
      irq_in       = '0;
      port_address = '0;
      port_out     = '0;
      port_write   = 1'b0;
      port_read    = 1'b0;
      irq_ack      = 1'b0;
      repeat (3) tick();
      checkOutput("rstIrqSignal", 16'(irq_signal), 16'd0);
      checkOutput("rstIrq", 16'(irq), 16'd0);
      checkOutput("rstPortReady", 16'(port_ready), 16'd0);
      checkOutput("rstPortIn", 16'(port_in), 16'd0);
      reset_n = 1'b1;
      repeat (2) tick();

      applyStimulus();

      // Single request, mask change while requesting, ack bookkeeping
      irq_in = 8'h02;
      waitIrq("s1Vec", 8'h09, 3);
      busWrite(16'h0021, 8'h02);
      checkOutput("s1HoldSig", 16'(irq_signal), 16'd1);
      checkOutput("s1HoldVec", 16'(irq), 16'h0009);
      busWrite(16'h0021, 8'h00);
      pulseAck();
      checkOutput("s1AckIdle", 16'(irq_signal), 16'd0);
      busRead(16'h0023, 8'h02);
      busRead(16'h0024, 8'h00);
      busRead(16'h0020, 8'h00);
      irq_in = 8'h00;
      busWrite(16'h0020, 8'h61);
      busRead(16'h0023, 8'h00);

      // Simultaneous requests on channels 3 and 5
      irq_in = 8'h28;
      waitIrq("s2First", 8'h0B, 3);
      pulseAck();
      checkOutput("s2AckIdle", 16'(irq_signal), 16'd0);
      expectIdle("s2Blocked", 2);
      busWrite(16'h0020, 8'h20);
      waitIrq("s2Second", 8'h0D, 3);
      pulseAck();
      busWrite(16'h0020, 8'h20);
      irq_in = 8'h00;
      busRead(16'h0023, 8'h00);

      // Nesting: channel 2 in service blocks 4, channel 0 preempts
      irq_in = 8'h04;
      waitIrq("s3Ch2", 8'h0A, 3);
      pulseAck();
      irq_in = 8'h14;
      expectIdle("s3Blocked", 4);
      irq_in = 8'h15;
      waitIrq("s3Nest", 8'h08, 3);
      pulseAck();
      busWrite(16'h0020, 8'h60);
      expectIdle("s3StillBlocked", 3);
      busWrite(16'h0020, 8'h62);
      waitIrq("s3Ch4", 8'h0C, 3);
      pulseAck();
      busWrite(16'h0020, 8'h20);
      irq_in = 8'h00;
      busRead(16'h0023, 8'h00);
      busRead(16'h0020, 8'h00);

      // Masked channel 0 and stray ack in IDLE
      busWrite(16'h0021, 8'h01);
      irq_in = 8'h01;
      expectIdle("s4Masked", 4);
      pulseAck();
      busRead(16'h0023, 8'h00);
      busRead(16'h0020, 8'h01);
      checkOutput("s4ReadyHigh", 16'(port_ready), 16'd1);
      tick();
      checkOutput("s4ReadyLow", 16'(port_ready), 16'd0);
      busWrite(16'h0021, 8'h00);
      waitIrq("s4Unmask", 8'h08, 3);
      pulseAck();
      busWrite(16'h0020, 8'h20);
      irq_in = 8'h00;

      // Rotating priority
      busWrite(16'h0020, 8'hA8);
      irq_in = 8'h01;
      waitIrq("s5Ch0", 8'h08, 3);
      pulseAck();
      busWrite(16'h0020, 8'h20);
      irq_in = 8'h00;
      tick();
      irq_in = 8'h03;
      waitIrq("s5Rotated", 8'h09, 3);
      pulseAck();
      expectIdle("s5Ch0Lowest", 2);
      busWrite(16'h0020, 8'h20);
      waitIrq("s5Ch0Later", 8'h08, 3);
      pulseAck();
      busWrite(16'h0020, 8'h20);
      busWrite(16'h0020, 8'hA0);
      irq_in = 8'h00;
      busRead(16'h0023, 8'h00);

      // New edge coinciding with ack, and an out-of-range specific EOI
      irq_in = 8'h08;
      waitIrq("s6Vec", 8'h0B, 3);
      irq_in = 8'h00;
      tick();
      irq_in  = 8'h08;
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      checkOutput("s6AckIdle", 16'(irq_signal), 16'd0);
      busRead(16'h0020, 8'h08);
      busRead(16'h0023, 8'h08);
      busWrite(16'h0020, 8'h6A);
      busRead(16'h0023, 8'h08);
      busWrite(16'h0020, 8'h63);
      waitIrq("s6Again", 8'h0B, 3);
      pulseAck();
      busWrite(16'h0020, 8'h20);
      irq_in = 8'h00;
      busRead(16'h0020, 8'h00);
      busRead(16'h0023, 8'h00);

      // EOI and ack in the same cycle
      irq_in = 8'h20;
      waitIrq("s7Ch5", 8'h0D, 3);
      pulseAck();
      irq_in = 8'h28;
      waitIrq("s7Ch3", 8'h0B, 3);
      port_address = 16'h0020;
      port_out     = 8'h20;
      port_write   = 1'b1;
      irq_ack      = 1'b1;
      tick();
      port_write   = 1'b0;
      irq_ack      = 1'b0;
      busRead(16'h0023, 8'h08);
      busWrite(16'h0020, 8'h20);
      irq_in = 8'h00;
      busRead(16'h0023, 8'h00);

      // Asynchronous reset during REQ with the line held high through reset
      irq_in = 8'h40;
      waitIrq("s8Vec", 8'h0E, 3);
      reset_n = 1'b0;
      #1;
      checkOutput("s8RstSig", 16'(irq_signal), 16'd0);
      checkOutput("s8RstIrq", 16'(irq), 16'd0);
      tick();
      tick();
      reset_n = 1'b1;
      expectIdle("s8NoEdge", 3);
      busRead(16'h0020, 8'h00);
      busRead(16'h0023, 8'h00);
      busRead(16'h0021, 8'h00);
      irq_in = 8'h00;
      tick();
      irq_in = 8'h40;
      waitIrq("s8Edge", 8'h0E, 3);
      pulseAck();
      busWrite(16'h0020, 8'h20);
      irq_in = 8'h00;

      repeat (2) tick();
      checkOutput("sbEmpty", 16'(readQueue.size()), 16'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
